// File: rtl/cu_pkg.sv
// Shared constants for the SAP-style control unit: opcodes, T-states,
// control-word bit positions and the named microcode words.
package cu_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [5:0] T_IDLE = 6'b000000;
  localparam logic [5:0] T1     = 6'b000001;
  localparam logic [5:0] T2     = 6'b000010;
  localparam logic [5:0] T3     = 6'b000100;
  localparam logic [5:0] T4     = 6'b001000;
  localparam logic [5:0] T5     = 6'b010000;
  localparam logic [5:0] T6     = 6'b100000;

  localparam int B_CP  = 11;
  localparam int B_EP  = 10;
  localparam int B_NLM = 9;
  localparam int B_NCE = 8;
  localparam int B_NLI = 7;
  localparam int B_NEI = 6;
  localparam int B_NLA = 5;
  localparam int B_EA  = 4;
  localparam int B_SU  = 3;
  localparam int B_EU  = 2;
  localparam int B_NLB = 1;
  localparam int B_NLO = 0;

  localparam logic [11:0] IDLE =
    (12'd1 << B_NLM) | (12'd1 << B_NCE) |
    (12'd1 << B_NLI) | (12'd1 << B_NEI) |
    (12'd1 << B_NLA) | (12'd1 << B_NLB) |
    (12'd1 << B_NLO);

  // Toggling a bit away from IDLE asserts it,
  // whatever its polarity.
  function automatic logic [11:0] cw(
    input logic [11:0] act
  );
    return IDLE ^ act;
  endfunction

  localparam logic [11:0] FETCH_T1 =
    cw((12'd1 << B_EP) | (12'd1 << B_NLM));
  localparam logic [11:0] FETCH_T2 =
    cw(12'd1 << B_CP);
  localparam logic [11:0] FETCH_T3 =
    cw((12'd1 << B_NCE) | (12'd1 << B_NLI));
  localparam logic [11:0] ADDR_T4 =
    cw((12'd1 << B_NLM) | (12'd1 << B_NEI));
  localparam logic [11:0] LDA_T5 =
    cw((12'd1 << B_NCE) | (12'd1 << B_NLA));
  localparam logic [11:0] ALU_T5 =
    cw((12'd1 << B_NCE) | (12'd1 << B_NLB));
  localparam logic [11:0] ADD_T6 =
    cw((12'd1 << B_NLA) | (12'd1 << B_EU));
  localparam logic [11:0] SUB_T6 =
    cw((12'd1 << B_NLA) | (12'd1 << B_SU) |
       (12'd1 << B_EU));
  localparam logic [11:0] OUT_T4 =
    cw((12'd1 << B_EA) | (12'd1 << B_NLO));
  localparam logic [11:0] LDI_T4 =
    cw((12'd1 << B_NEI) | (12'd1 << B_NLA));

endpackage

// File: rtl/cu_decode.sv
// Combinational microcode decode: (t_state_i, ir_op_i) -> ctrl_o.
// Non-one-hot states and undefined steps give IDLE. Macro: CU_EXT_OPS_EN (LDI).
module cu_decode
  import cu_pkg::*;
(
  input  logic [5:0]  t_state_i,
  input  logic [3:0]  ir_op_i,
  output logic [11:0] ctrl_o
);

  always_comb begin
    ctrl_o = IDLE;
    case (t_state_i)
      T1: ctrl_o = FETCH_T1;
      T2: ctrl_o = FETCH_T2;
      T3: ctrl_o = FETCH_T3;
      T4: begin
        case (ir_op_i)
          OP_LDA,
          OP_ADD,
          OP_SUB:  ctrl_o = ADDR_T4;
          OP_OUT:  ctrl_o = OUT_T4;
`ifdef CU_EXT_OPS_EN
          OP_LDI:  ctrl_o = LDI_T4;
`endif
          default: ctrl_o = IDLE;
        endcase
      end
      T5: begin
        case (ir_op_i)
          OP_LDA:  ctrl_o = LDA_T5;
          OP_ADD,
          OP_SUB:  ctrl_o = ALU_T5;
          default: ctrl_o = IDLE;
        endcase
      end
      T6: begin
        case (ir_op_i)
          OP_ADD:  ctrl_o = ADD_T6;
          OP_SUB:  ctrl_o = SUB_T6;
          default: ctrl_o = IDLE;
        endcase
      end
      default: ctrl_o = IDLE;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Control unit top: decode plus halt latch, sticky t_err, instr_cnt.
// Ports: CLK, nCLR, t_state, ir_op -> ctrl, nHLT, t_err, instr_cnt. Macro: CU_EXT_OPS_EN.
module control_unit
  import cu_pkg::*;
(
  input  logic        CLK,
  input  logic        nCLR,
  input  logic [5:0]  t_state,
  input  logic [3:0]  ir_op,
  output logic [11:0] ctrl,
  output logic        nHLT,
  output logic        t_err,
  output logic [7:0]  instr_cnt
);

  logic [11:0] dec_ctrl;
  logic        halt_q, halt_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_t4;
  logic        illegal;

  cu_decode u_dec (
    .t_state_i (t_state),
    .ir_op_i   (ir_op),
    .ctrl_o    (dec_ctrl)
  );

  assign is_t4   = (t_state == T4);
  // More than one bit set: x & (x-1) clears only the lowest.
  assign illegal = (t_state & (t_state - 6'd1)) != 6'd0;

  always_comb begin
    halt_d = halt_q;
    err_d  = err_q | illegal;
    cnt_d  = cnt_q;
    if (is_t4 && !halt_q) begin
      cnt_d = cnt_q + 8'd1;
      if (ir_op == OP_HLT) halt_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      halt_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= 8'h00;
    end else begin
      halt_q <= halt_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ctrl      = halt_q ? IDLE : dec_ctrl;
  assign nHLT      = ~halt_q;
  assign t_err     = err_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed steps plus random
// T-state/opcode traffic against a table-driven reference model.
module tb_control_unit;

  logic        CLK = 1'b0;
  logic        nCLR = 1'b0;
  logic [5:0]  t_state = 6'd0;
  logic [3:0]  ir_op = 4'd0;
  logic [11:0] ctrl;
  logic        nHLT;
  logic        t_err;
  logic [7:0]  instr_cnt;

  int n_chk = 0;
  int n_fail = 0;

  bit       m_halt = 1'b0;
  bit       m_err = 1'b0;
  bit [7:0] m_cnt = 8'h00;

  control_unit dut (
    .CLK       (CLK),
    .nCLR      (nCLR),
    .t_state   (t_state),
    .ir_op     (ir_op),
    .ctrl      (ctrl),
    .nHLT      (nHLT),
    .t_err     (t_err),
    .instr_cnt (instr_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] ref_ctrl(
    input logic [5:0] ts,
    input logic [3:0] op,
    input bit h
  );
    int k;
    logic [11:0] r;
    r = 12'h3E3;
    if (h || $countones(ts) != 1) return r;
    k = 0;
    for (int i = 0; i < 6; i++)
      if (ts[i]) k = i + 1;
    case (k)
      1: r = 12'h5E3;
      2: r = 12'hBE3;
      3: r = 12'h263;
      default: begin
        case (op)
          4'b0000: r = (k == 4) ? 12'h1A3 :
                       (k == 5) ? 12'h2C3 : 12'h3E3;
          4'b0001: r = (k == 4) ? 12'h1A3 :
                       (k == 5) ? 12'h2E1 : 12'h3C7;
          4'b0010: r = (k == 4) ? 12'h1A3 :
                       (k == 5) ? 12'h2E1 : 12'h3CF;
          4'b1110: r = (k == 4) ? 12'h3F2 : 12'h3E3;
`ifdef CU_EXT_OPS_EN
          4'b0101: r = (k == 4) ? 12'h383 : 12'h3E3;
`endif
          default: r = 12'h3E3;
        endcase
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [11:0] got,
                     input logic [11:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".nHLT"}, {11'd0, nHLT},
        {11'd0, ~m_halt});
    chk({tag, ".t_err"}, {11'd0, t_err},
        {11'd0, m_err});
    chk({tag, ".cnt"}, {4'd0, instr_cnt},
        {4'd0, m_cnt});
  endtask

  task automatic step(input string tag,
                      input logic [5:0] ts,
                      input logic [3:0] op);
    @(negedge CLK);
    t_state = ts;
    ir_op = op;
    #1;
    chk({tag, ".ctrl"}, ctrl,
        ref_ctrl(ts, op, m_halt));
    @(posedge CLK);
    if ($countones(ts) > 1) m_err = 1'b1;
    if (ts == 6'b001000 && !m_halt) begin
      m_cnt = m_cnt + 8'd1;
      if (op == 4'b1111) m_halt = 1'b1;
    end
    #1;
    chk_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    #2;
    nCLR = 1'b0;
    m_halt = 1'b0;
    m_err = 1'b0;
    m_cnt = 8'h00;
    #1;
    chk_regs({tag, ".async"});
    chk({tag, ".ctrl"}, ctrl,
        ref_ctrl(t_state, ir_op, 1'b0));
    t_state = 6'd0;
    @(posedge CLK);
    #1;
    chk_regs({tag, ".held"});
    chk({tag, ".idle"}, ctrl, 12'h3E3);
    @(negedge CLK);
    #2;
    nCLR = 1'b1;
  endtask

  initial begin
    logic [5:0] ts;
    logic [3:0] op;

    do_reset("rst0");
    step("f1", 6'b000001, 4'b0001);
    step("f2", 6'b000010, 4'b0001);
    step("f3", 6'b000100, 4'b0001);
    step("add4", 6'b001000, 4'b0001);
    step("add5", 6'b010000, 4'b0001);
    step("add6", 6'b100000, 4'b0001);
    for (int i = 0; i < 6; i++)
      step("sub", 6'd1 << i, 4'b0010);
    for (int i = 0; i < 6; i++)
      step("lda", 6'd1 << i, 4'b0000);
    for (int i = 0; i < 6; i++)
      step("out", 6'd1 << i, 4'b1110);
    for (int i = 0; i < 6; i++)
      step("ldi", 6'd1 << i, 4'b0101);
    for (int i = 0; i < 6; i++)
      step("nop", 6'd1 << i, 4'b0111);
    step("idle", 6'b000000, 4'b0001);

    for (int i = 0; i < 4; i++)
      step("hlt", 6'd1 << i, 4'b1111);
    for (int i = 0; i < 6; i++)
      step("halted", 6'd1 << i, 4'b0000);
    do_reset("rst1");

    step("ill", 6'b000011, 4'b0001);
    for (int i = 0; i < 6; i++)
      step("post_ill", 6'd1 << i, 4'b0001);
    do_reset("rst2");
    step("after_rst", 6'b000001, 4'b0001);

    do_reset("rst3");
    for (int i = 0; i < 256; i++)
      step("wrap", 6'b001000, 4'b0011);
    chk("wrap.final", {4'd0, instr_cnt}, 12'h000);

    do_reset("rst4");
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: ts = 6'd0;
        1: ts = 6'($urandom);
        default: ts = 6'd1 << $urandom_range(0, 5);
      endcase
      op = 4'($urandom);
      if ($urandom_range(0, 7) == 0) op = 4'b1111;
      step("rnd", ts, op);
      if (i % 50 == 49) do_reset("rst_rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
